// File: rtl/buffer_pkgs.sv
// Shared types and sizes for the reorder buffer and its neighbours.
//   ROB_DEPTH / ROB_PTR_W : entry count and tag width
//   PREG_W                : physical register index width
//   rob_entry_t           : one in-flight instruction
//   wb_packet_t           : completion packet from a writeback port
//   rob_commit_t          : retirement record sent to commit logic
package buffer_pkgs;
  localparam int ROB_DEPTH = 16;
  localparam int ROB_PTR_W = $clog2(ROB_DEPTH);
  localparam int PREG_W    = 7;
  localparam int NUM_WB    = 3;

  typedef struct packed {
    logic              valid;
    logic              completed;
    logic              has_dest;
    logic [4:0]        arch_rd;
    logic [PREG_W-1:0] dest_preg;
    logic [PREG_W-1:0] old_preg;
    logic              is_branch;
    logic [31:0]       pc;
  } rob_entry_t;

  typedef struct packed {
    logic                 completed;
    logic                 mispredict;
    logic [ROB_PTR_W-1:0] tag;
    logic [31:0]          dest_addr;
  } wb_packet_t;

  typedef struct packed {
    logic              has_dest;
    logic [4:0]        arch_rd;
    logic [PREG_W-1:0] dest_preg;
    logic [PREG_W-1:0] old_preg;
    logic [31:0]       pc;
  } rob_commit_t;
endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement buffer.
//   clk, reset         : clock, synchronous active-high reset
//   alloc_*            : dispatch allocation (ready/tag combinational)
//   wb_alu/lsu/br      : completion packets, valid when .completed
//   commit_valid/info  : registered retirement, one per cycle
//   flush/flush_pc     : registered one-cycle mispredict redirect
//   rob_count          : occupancy 0..ROB_DEPTH
module reorder_buffer
  import buffer_pkgs::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 alloc_valid,
  output logic                 alloc_ready,
  output logic [ROB_PTR_W-1:0] alloc_tag,
  input  logic                 alloc_has_dest,
  input  logic [4:0]           alloc_arch_rd,
  input  logic [PREG_W-1:0]    alloc_dest_preg,
  input  logic [PREG_W-1:0]    alloc_old_preg,
  input  logic                 alloc_is_branch,
  input  logic [31:0]          alloc_pc,
  input  wb_packet_t           wb_alu,
  input  wb_packet_t           wb_lsu,
  input  wb_packet_t           wb_br,
  output logic                 commit_valid,
  output rob_commit_t          commit_info,
  output logic                 flush,
  output logic [31:0]          flush_pc,
  output logic [ROB_PTR_W:0]   rob_count
);

  rob_entry_t           r_entries [ROB_DEPTH];
  logic [ROB_PTR_W-1:0] r_head, r_tail;
  logic [ROB_PTR_W:0]   r_count;

  wb_packet_t           w_wb [NUM_WB];
  logic [ROB_DEPTH-1:0] w_hit [NUM_WB];
  logic [ROB_DEPTH-1:0] w_done, w_squash;
  logic                 w_fire, w_commit, w_mispredict;
  logic [ROB_PTR_W-1:0] w_head_next, w_young_span, w_ptr_diff;
  logic [ROB_PTR_W:0]   w_count_next;
  logic                 w_unused;

  assign w_wb[0] = wb_alu;
  assign w_wb[1] = wb_lsu;
  assign w_wb[2] = wb_br;

  // One-hot decode of each completion port's tag.
  for (genvar p = 0; p < NUM_WB; p++) begin : g_wb_dec
    assign w_hit[p] = w_wb[p].completed ? (ROB_DEPTH'(1) << w_wb[p].tag) : '0;
  end

  assign alloc_ready  = (r_count != (ROB_PTR_W+1)'(ROB_DEPTH));
  assign alloc_tag    = r_tail;
  assign rob_count    = r_count;
  assign w_fire       = alloc_valid && alloc_ready;
  assign w_commit     = r_entries[r_head].valid && r_entries[r_head].completed;
  assign w_head_next  = r_head + ROB_PTR_W'(w_commit);
  assign w_mispredict = wb_br.completed && wb_br.mispredict && r_entries[wb_br.tag].valid;
  // Number of entries strictly younger than the branch (tag+1 .. tail-1).
  assign w_young_span = r_tail - wb_br.tag - ROB_PTR_W'(1);
  assign w_ptr_diff   = wb_br.tag - w_head_next;

  always_comb begin
    w_done   = '0;
    w_squash = '0;
    for (int p = 0; p < NUM_WB; p++) w_done = w_done | w_hit[p];
    for (int i = 0; i < ROB_DEPTH; i++)
      w_squash[i] = w_mispredict &&
                    ((ROB_PTR_W'(i) - wb_br.tag - ROB_PTR_W'(1)) < w_young_span);
  end

  always_comb begin
    if (w_mispredict)
      w_count_next = {1'b0, w_ptr_diff} + (ROB_PTR_W+1)'(1);
    else
      w_count_next = r_count + (ROB_PTR_W+1)'(w_fire) - (ROB_PTR_W+1)'(w_commit);
  end

  // Fields carried through but not consumed here.
  always_comb begin
    w_unused = ^{wb_alu.mispredict, wb_alu.dest_addr, wb_lsu.mispredict, wb_lsu.dest_addr};
    for (int i = 0; i < ROB_DEPTH; i++) w_unused = w_unused ^ r_entries[i].is_branch;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ROB_DEPTH; i++) r_entries[i] <= '0;
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      commit_valid <= 1'b0;
      commit_info  <= '0;
      flush        <= 1'b0;
      flush_pc     <= '0;
    end else begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        if (w_done[i] && r_entries[i].valid) r_entries[i].completed <= 1'b1;
        if (w_squash[i])                     r_entries[i].valid     <= 1'b0;
      end
      if (w_commit) r_entries[r_head].valid <= 1'b0;
      // An allocation racing a mispredict is dropped; upstream kills it on flush.
      if (w_fire && !w_mispredict)
        r_entries[r_tail] <= '{valid: 1'b1, completed: 1'b0, has_dest: alloc_has_dest,
                               arch_rd: alloc_arch_rd, dest_preg: alloc_dest_preg,
                               old_preg: alloc_old_preg, is_branch: alloc_is_branch,
                               pc: alloc_pc};
      r_head  <= w_head_next;
      r_count <= w_count_next;
      if (w_mispredict)     r_tail <= wb_br.tag + ROB_PTR_W'(1);
      else if (w_fire)      r_tail <= r_tail + ROB_PTR_W'(1);

      commit_valid <= w_commit;
      if (w_commit)
        commit_info <= '{has_dest: r_entries[r_head].has_dest,
                         arch_rd: r_entries[r_head].arch_rd,
                         dest_preg: r_entries[r_head].dest_preg,
                         old_preg: r_entries[r_head].old_preg,
                         pc: r_entries[r_head].pc};
      flush <= w_mispredict;
      if (w_mispredict) flush_pc <= wb_br.dest_addr;
    end
  end

endmodule
